// File: rtl/dsm7_2nd_mod.sv
// dsm7_2nd_mod: second-order error-feedback delta-sigma modulator, NTF = (1 - z^-1)^2.
// A 7-level quantizer produces the element count V (0..6) for the 6-element DEM stage
// downstream. The input is held between din_vld strobes. A run of consecutive clamped
// (overloaded) ticks clears the loop state, pulses ovld and bumps a saturating event count.
module dsm7_2nd_mod #(
  parameter int DW        = 16,
  parameter int EW        = 20,
  parameter int STEP_LOG2 = 13,
  parameter int OVLD_LIM  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          en,
  input  logic          clr_sts,
  output logic [3:0]    V,
  output logic          ovld,
  output logic [7:0]    ovld_cnt
);

  // Loop arithmetic is carried two bits wider than the error state. This leaves
  // headroom for hold - 2*e1 + e2 with both error registers at full scale.
  localparam int AW = EW + 2;

  // Adding 3.5 steps before the floor divide gives round-half-up quantization
  // onto levels 0..6, where level k stands for (k-3) steps.
  localparam logic signed [AW-1:0] OFFS     = AW'(3 * (2 ** STEP_LOG2) + 2 ** (STEP_LOG2 - 1));
  localparam logic signed [AW-1:0] HALF_POS = AW'(2 ** (STEP_LOG2 - 1));
  localparam logic signed [AW-1:0] HALF_NEG = -HALF_POS;
  localparam logic signed [AW-1:0] EMAX_POS = AW'(2 ** (EW - 1) - 1);
  localparam logic signed [AW-1:0] EMAX_NEG = -EMAX_POS;
  localparam logic signed [EW-1:0] ESAT_POS = EW'(2 ** (EW - 1) - 1);
  localparam logic signed [EW-1:0] ESAT_NEG = -ESAT_POS;
  localparam logic signed [AW-1:0] LVL_LO   = '0;
  localparam logic signed [AW-1:0] LVL_HI   = AW'(6);
  localparam logic signed [AW-1:0] LVL_MID  = AW'(3);
  localparam logic [7:0]           RUN_LAST = 8'(OVLD_LIM - 1);
  localparam logic [3:0]           V_MID    = 4'd3;
  localparam logic [7:0]           CNT_MAX  = 8'hFF;

  logic signed [DW-1:0] hold;
  logic signed [EW-1:0] e1;
  logic signed [EW-1:0] e2;
  logic [7:0]           run;

  logic signed [AW-1:0] holdx;
  logic signed [AW-1:0] e1x;
  logic signed [AW-1:0] e2x;
  logic signed [AW-1:0] u;
  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] q;
  logic [2:0]           k;
  logic signed [AW-1:0] kx;
  logic signed [AW-1:0] y;
  logic signed [AW-1:0] ediff;
  logic signed [EW-1:0] e;
  logic                 over;
  logic                 hit;

  // Quantizer: form the loop input and pick the nearest of the 7 levels.
  // When the floor result falls outside 0..6, the level is clamped.
  always_comb begin
    holdx  = AW'(hold);
    e1x    = AW'(e1);
    e2x    = AW'(e2);
    u      = holdx - (e1x <<< 1) + e2x;
    biased = u + OFFS;
    q      = biased >>> STEP_LOG2;
    if (q < LVL_LO) begin
      k = 3'd0;
    end else if (q > LVL_HI) begin
      k = 3'd6;
    end else begin
      k = q[2:0];
    end
  end

  // Quantization error is fed back saturated. Without clamping, an error beyond
  // half a step can only come from a clamped level, which is what marks an
  // overloaded tick.
  always_comb begin
    kx    = AW'(k);
    y     = (kx - LVL_MID) <<< STEP_LOG2;
    ediff = y - u;
    if (ediff > EMAX_POS) begin
      e = ESAT_POS;
    end else if (ediff < EMAX_NEG) begin
      e = ESAT_NEG;
    end else begin
      e = ediff[EW-1:0];
    end
    over = (ediff > HALF_POS) || (ediff < HALF_NEG);
    hit  = over && (run == RUN_LAST);
  end

  // The sample hold register follows din_vld regardless of the run enable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold <= '0;
    end else if (din_vld) begin
      hold <= signed'(din);
    end
  end

  // Loop state, run counter and outputs advance on enabled ticks.
  // Disabled ticks freeze the loop and park V at mid-scale.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e1   <= '0;
      e2   <= '0;
      run  <= '0;
      V    <= V_MID;
      ovld <= 1'b0;
    end else if (en) begin
      V    <= {1'b0, k};
      ovld <= hit;
      if (hit) begin
        e1  <= '0;
        e2  <= '0;
        run <= '0;
      end else begin
        e2  <= e1;
        e1  <= e;
        run <= over ? run + 8'd1 : 8'd0;
      end
    end else begin
      V    <= V_MID;
      ovld <= 1'b0;
    end
  end

  // Recovery event counter saturates at 255. A status clear overrides a
  // recovery event that lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovld_cnt <= '0;
    end else if (clr_sts) begin
      ovld_cnt <= '0;
    end else if (en && hit && (ovld_cnt != CNT_MAX)) begin
      ovld_cnt <= ovld_cnt + 8'd1;
    end
  end

endmodule
